mmul_parallel_addr_gen: RTL and testbench

- Strided address generator for one mmul_parallel input source stream (one instance each for in1 and in2).
- Sits downstream of the control/FSM stage, which drives the per-stream trans_size, line/feat stride/length, roll, loop_outer and step values.
- On a start pulse it emits a sequence of word addresses over a valid/ready handshake toward the source streamer, then pulses done.

---
 rtl/mmul_parallel_addr_gen.sv | 161 ++++++++++++++++
 tb/tb_mmul_parallel_addr_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mmul_parallel_addr_gen.sv
// mmul_parallel_addr_gen: strided word-address generator for one mmul_parallel source stream.
// Ports: clk_i/rst_i/clear_i (sync, active-high), start_i + configuration (base, trans_size, step,
// line/feat length+stride, feat_roll, loop_outer) sampled on start, addr_o/addr_valid_o/addr_ready_i
// handshake, busy_o, done_o pulse, sticky cfg_err_o, perf_stall_o.
// Optional MMUL_PARALLEL_ADDR_GEN_PERF_EN builds the saturating stall counter behind perf_stall_o.
module mmul_parallel_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  trans_size_i,
    input  logic [ADDR_WIDTH-1:0] step_i,
    input  logic [CNT_WIDTH-1:0]  line_length_i,
    input  logic [ADDR_WIDTH-1:0] line_stride_i,
    input  logic [CNT_WIDTH-1:0]  feat_length_i,
    input  logic [ADDR_WIDTH-1:0] feat_stride_i,
    input  logic [CNT_WIDTH-1:0]  feat_roll_i,
    input  logic                  loop_outer_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_valid_o,
    input  logic                  addr_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o,
    output logic [CNT_WIDTH-1:0]  perf_stall_o
);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] line_stride;
        logic [ADDR_WIDTH-1:0] feat_stride;
        logic [CNT_WIDTH-1:0]  trans_size;
        logic [CNT_WIDTH-1:0]  line_length;
        logic [CNT_WIDTH-1:0]  feat_length;
        logic [CNT_WIDTH-1:0]  feat_roll;
        logic                  loop_outer;
    } cfg_t;
    state_t                state_q, state_d;
    cfg_t                  cfg_q, cfg_d;
    logic [ADDR_WIDTH-1:0] word_ptr_q, word_ptr_d, line_ptr_q, line_ptr_d, feat_ptr_q, feat_ptr_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d, line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0]  feat_cnt_q, feat_cnt_d, tot_cnt_q, tot_cnt_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  cfg_bad;

    assign cfg_bad = line_length_i == '0 || feat_length_i == '0 || (loop_outer_i && feat_roll_i == '0);

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        word_ptr_d = word_ptr_q;
        line_ptr_d = line_ptr_q;
        feat_ptr_d = feat_ptr_q;
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        feat_cnt_d = feat_cnt_q;
        tot_cnt_d  = tot_cnt_q;
        cfg_err_d  = cfg_err_q;
        case (state_q)
            IDLE: if (start_i) begin
                cfg_d = '{base: base_addr_i, step: step_i, line_stride: line_stride_i,
                          feat_stride: feat_stride_i, trans_size: trans_size_i,
                          line_length: line_length_i, feat_length: feat_length_i,
                          feat_roll: feat_roll_i, loop_outer: loop_outer_i};
                cfg_err_d  = cfg_bad;
                word_ptr_d = base_addr_i;
                line_ptr_d = base_addr_i;
                feat_ptr_d = base_addr_i;
                word_cnt_d = '0;
                line_cnt_d = '0;
                feat_cnt_d = '0;
                tot_cnt_d  = '0;
                state_d    = (trans_size_i == '0 || cfg_bad) ? DONE : RUN;
            end
            RUN: if (addr_ready_i) begin
                tot_cnt_d  = tot_cnt_q + ONE;
                word_cnt_d = word_cnt_q + ONE;
                word_ptr_d = word_ptr_q + cfg_q.step;
                // Line wrap, then feature wrap, then optional roll back to base, each overriding the last.
                if (word_cnt_q == cfg_q.line_length - ONE) begin
                    line_ptr_d = line_ptr_q + cfg_q.line_stride;
                    word_ptr_d = line_ptr_d;
                    word_cnt_d = '0;
                    line_cnt_d = line_cnt_q + ONE;
                    if (line_cnt_q == cfg_q.feat_length - ONE) begin
                        feat_ptr_d = feat_ptr_q + cfg_q.feat_stride;
                        line_ptr_d = feat_ptr_d;
                        word_ptr_d = feat_ptr_d;
                        line_cnt_d = '0;
                        feat_cnt_d = feat_cnt_q + ONE;
                        if (cfg_q.loop_outer && feat_cnt_d == cfg_q.feat_roll) begin
                            feat_ptr_d = cfg_q.base;
                            line_ptr_d = cfg_q.base;
                            word_ptr_d = cfg_q.base;
                            feat_cnt_d = '0;
                        end
                    end
                end
                if (tot_cnt_q == cfg_q.trans_size - ONE) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            word_ptr_q <= '0;
            line_ptr_q <= '0;
            feat_ptr_q <= '0;
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            feat_cnt_q <= '0;
            tot_cnt_q  <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            word_ptr_q <= word_ptr_d;
            line_ptr_q <= line_ptr_d;
            feat_ptr_q <= feat_ptr_d;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
            feat_cnt_q <= feat_cnt_d;
            tot_cnt_q  <= tot_cnt_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign addr_o       = word_ptr_q;
    assign addr_valid_o = state_q == RUN;
    assign busy_o       = state_q == RUN;
    assign done_o       = state_q == DONE;
    assign cfg_err_o    = cfg_err_q;

`ifdef MMUL_PARALLEL_ADDR_GEN_PERF_EN
    logic [CNT_WIDTH-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = (state_q == IDLE && start_i) ? '0 :
                 (state_q == RUN && !addr_ready_i && perf_q != '1) ? perf_q + ONE : perf_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) perf_q <= '0;
        else perf_q <= perf_d;
    end

    assign perf_stall_o = perf_q;
`else
    assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_mmul_parallel_addr_gen.sv
// tb_mmul_parallel_addr_gen: randomized bench with an arithmetic address model for mmul_parallel_addr_gen.
module tb_mmul_parallel_addr_gen;
    logic        clk_i = 0, rst_i = 1, clear_i = 0, start_i = 0, loop_outer_i = 0, addr_ready_i = 1;
    logic [31:0] base_addr_i = 0, step_i = 0, line_stride_i = 0, feat_stride_i = 0, addr_o;
    logic [15:0] trans_size_i = 0, line_length_i = 0, feat_length_i = 0, feat_roll_i = 0, perf_stall_o;
    logic        addr_valid_o, busy_o, done_o, cfg_err_o;

    mmul_parallel_addr_gen dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .trans_size_i(trans_size_i), .step_i(step_i),
        .line_length_i(line_length_i), .line_stride_i(line_stride_i),
        .feat_length_i(feat_length_i), .feat_stride_i(feat_stride_i),
        .feat_roll_i(feat_roll_i), .loop_outer_i(loop_outer_i),
        .addr_o(addr_o), .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
        .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o), .perf_stall_o(perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;
    bit chk_en = 0;
    int rmode = 0, cyc = 0;
    // Model: what the outputs must be this cycle.
    bit m_run = 0, m_done = 0, m_err = 0;
    int m_stall = 0, n_xfer = 0, exp_n = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_base, m_step, m_ls, m_fs;
    int m_ll, m_fl, m_roll;
    bit m_loop;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Address of transfer k straight from the nested-loop definition.
    function automatic logic [31:0] model_addr(int k);
        int w, l, f;
        w = k % m_ll;
        l = (k / m_ll) % m_fl;
        f = k / (m_ll * m_fl);
        if (m_loop) f = f % m_roll;
        return m_base + f * m_fs + l * m_ls + w * m_step;
    endfunction

    always @(negedge clk_i) if (chk_en) begin
        chk("valid", {31'b0, addr_valid_o}, {31'b0, m_run});
        chk("busy", {31'b0, busy_o}, {31'b0, m_run});
        chk("done", {31'b0, done_o}, {31'b0, m_done});
        chk("cfg_err", {31'b0, cfg_err_o}, {31'b0, m_err});
        chk("perf", {16'b0, perf_stall_o}, m_stall);
        if (m_run) chk("addr", addr_o, exp_q[0]);
        if (rst_i || clear_i) begin
            m_run = 0; m_done = 0; m_err = 0; m_stall = 0;
            exp_q.delete();
        end else if (m_run) begin
            if (addr_ready_i) begin
                void'(exp_q.pop_front());
                n_xfer++;
                if (exp_q.size() == 0) begin m_run = 0; m_done = 1; end
            end
`ifdef MMUL_PARALLEL_ADDR_GEN_PERF_EN
            else if (m_stall != 16'hffff) m_stall++;
`endif
        end else if (m_done) m_done = 0;
        else if (start_i) begin
            m_base = base_addr_i; m_step = step_i; m_ls = line_stride_i; m_fs = feat_stride_i;
            m_ll = int'(line_length_i); m_fl = int'(feat_length_i); m_roll = int'(feat_roll_i);
            m_loop = loop_outer_i;
            m_err = m_ll == 0 || m_fl == 0 || (m_loop && m_roll == 0);
            m_stall = 0;
            n_xfer = 0;
            exp_q.delete();
            if (!m_err) for (int k = 0; k < int'(trans_size_i); k++) exp_q.push_back(model_addr(k));
            exp_n = exp_q.size();
            if (exp_n > 0) m_run = 1; else m_done = 1;
        end
    end

    initial forever begin
        @(posedge clk_i); #1;
        cyc++;
        addr_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? ~cyc[0] : 1'($urandom_range(0, 1));
    end

    task automatic set_cfg(input logic [31:0] b, st, ls, fs, input logic [15:0] ts, ll, fl, ro, input bit lo);
        base_addr_i = b; step_i = st; line_stride_i = ls; feat_stride_i = fs;
        trans_size_i = ts; line_length_i = ll; feat_length_i = fl; feat_roll_i = ro; loop_outer_i = lo;
    endtask

    task automatic scramble();
        set_cfg($urandom, $urandom, $urandom, $urandom, 16'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), 1'($urandom));
    endtask

    task automatic start_job(input bit mid_start);
        @(posedge clk_i); #1 start_i = 1;
        @(posedge clk_i); #1 start_i = 0;
        scramble();
        if (mid_start) begin
            @(posedge clk_i); #1 start_i = 1;
            @(posedge clk_i); #1 start_i = 0;
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk_i); #2;
            ok = !m_run && !m_done;
        end
        if (!ok) begin
            errors++;
            $display("FAIL timeout job did not finish");
        end
        chk("xfer_count", n_xfer, exp_n);
    endtask

    logic [31:0] nom[8] = '{32'h1000, 32'h1004, 32'h1008, 32'h1040, 32'h1044, 32'h1048, 32'h1400, 32'h1404};
    logic [31:0] rol[5] = '{32'h0, 32'h100, 32'h0, 32'h100, 32'h0};

    initial begin
        repeat (2) @(posedge clk_i);
        #1 chk_en = 1;
        @(negedge clk_i);
        chk("reset_addr", addr_o, 32'h0);
        @(posedge clk_i); #1 rst_i = 0;

        // Nominal, then pin the model against the hand-computed list.
        set_cfg(32'h1000, 4, 32'h40, 32'h400, 8, 3, 2, 0, 0);
        start_job(0);
        chk("nom_len", exp_q.size(), 8);
        for (int i = 0; i < 8; i++) chk("pin_nom", exp_q[i], nom[i]);
        wait_idle();

        // Backpressure on every odd cycle.
        rmode = 1;
        set_cfg(32'h1000, 4, 32'h40, 32'h400, 8, 3, 2, 0, 0);
        start_job(0);
        wait_idle();
        rmode = 0;

        // Feature roll.
        set_cfg(32'h0, 4, 32'h40, 32'h100, 5, 1, 1, 2, 1);
        start_job(0);
        for (int i = 0; i < 5; i++) chk("pin_roll", exp_q[i], rol[i]);
        wait_idle();

        // Degenerate configurations.
        set_cfg(32'h10, 4, 4, 4, 0, 2, 2, 0, 0); start_job(0); wait_idle();
        set_cfg(32'h10, 4, 4, 4, 5, 0, 2, 0, 0); start_job(0); wait_idle();
        chk("err_sticky", {31'b0, cfg_err_o}, 32'h1);
        set_cfg(32'h10, 4, 4, 4, 5, 2, 0, 0, 0); start_job(0); wait_idle();
        set_cfg(32'h10, 4, 4, 4, 5, 2, 2, 0, 1); start_job(0); wait_idle();

        // Abort after three transfers, then replay from base.
        set_cfg(32'h1000, 4, 32'h40, 32'h400, 8, 3, 2, 0, 0);
        start_job(0);
        for (int i = 0; i < 50 && n_xfer < 3; i++) begin @(posedge clk_i); #1; end
        clear_i = 1;
        @(posedge clk_i); #1 clear_i = 0;
        repeat (3) @(posedge clk_i);
        set_cfg(32'h1000, 4, 32'h40, 32'h400, 8, 3, 2, 0, 0);
        start_job(1);
        wait_idle();

        // Randomized jobs, some with a stray start mid-run and random backpressure.
        for (int j = 0; j < 30; j++) begin
            rmode = $urandom_range(0, 2);
            set_cfg($urandom, $urandom, $urandom, $urandom, 16'($urandom_range(4, 30)),
                    16'($urandom_range(1, 4)), 16'($urandom_range(1, 3)), 16'($urandom_range(1, 3)),
                    1'($urandom_range(0, 1)));
            start_job(1'($urandom_range(0, 1)));
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
